// File: rtl/fq_scheduler.sv
// fq_scheduler
// Multi-channel frequency measurement scheduler. Requesting channels are
// granted round-robin; the granted channel's rising edges are counted over
// a gate window of max(gate_cycles,1) reference cycles and the count is
// returned through a valid/ready handshake.
//
// Ports
//   ref_freq    reference clock, all logic on its rising edge
//   Reset       asynchronous active-high reset
//   req         per-channel request level, held until that channel's handshake
//   sig_in      measured signals, asynchronous to ref_freq
//   gate_cycles gate window length in ref_freq cycles, sampled at grant
//   busy        high from grant until handshake or abort
//   cur_ch      currently granted channel (holds last grant while idle)
//   result      saturating edge count of the completed measurement
//   result_ch   channel that result belongs to
//   overflow    count saturated during this measurement
//   valid       result available
//   ready       consumer accepts result when valid && ready
module fq_scheduler #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                ref_freq,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] sig_in,
  input  logic [31:0]         gate_cycles,
  output logic                busy,
  output logic [CH_W-1:0]     cur_ch,
  output logic [WIDTH-1:0]    result,
  output logic [CH_W-1:0]     result_ch,
  output logic                overflow,
  output logic                valid,
  input  logic                ready
);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] s1_q, s2_q, s3_q;
  logic [CHANNELS-1:0] rise;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [WIDTH-1:0]    edge_cnt_q, edge_cnt_d;
  logic [31:0]         gate_cnt_q, gate_cnt_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [CH_W-1:0]     result_ch_q, result_ch_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                grant_found;
  logic [CH_W-1:0]     grant_ch;
  logic [CH_W:0]       scan_sum;
  logic [CH_W-1:0]     next_ch;

  // Every channel is synchronised continuously so a new grant can count at once.
  always_ff @(posedge ref_freq or posedge Reset) begin
    if (Reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign next_ch = (cur_ch_q == CH_W'(CHANNELS - 1)) ? '0 : cur_ch_q + CH_W'(1);

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo CHANNELS.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    scan_sum    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (CH_W + 1)'(i);
      if (scan_sum >= (CH_W + 1)'(CHANNELS)) scan_sum = scan_sum - (CH_W + 1)'(CHANNELS);
      if (!grant_found && req[scan_sum[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = scan_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_ch_d    = cur_ch_q;
    edge_cnt_d  = edge_cnt_q;
    gate_cnt_d  = gate_cnt_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    overflow_d  = overflow_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          cur_ch_d   = grant_ch;
          edge_cnt_d = '0;
          gate_cnt_d = (gate_cycles == 32'd0) ? 32'd1 : gate_cycles;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_GATE;
        end
      end
      S_GATE: begin
        if (!req[cur_ch_q]) begin
          busy_d   = 1'b0;
          rr_ptr_d = next_ch;
          state_d  = S_IDLE;
        end else begin
          // Overflow marks an edge lost while the counter sits at all-ones.
          if (rise[cur_ch_q]) begin
            if (edge_cnt_q == '1) overflow_d = 1'b1;
            else                  edge_cnt_d = edge_cnt_q + WIDTH'(1);
          end
          gate_cnt_d = gate_cnt_q - 32'd1;
          if (gate_cnt_q == 32'd1) begin
            result_d    = edge_cnt_d;
            result_ch_d = cur_ch_q;
            valid_d     = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (ready) begin
          valid_d  = 1'b0;
          busy_d   = 1'b0;
          rr_ptr_d = next_ch;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ref_freq or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cur_ch_q    <= '0;
      edge_cnt_q  <= '0;
      gate_cnt_q  <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      edge_cnt_q  <= edge_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign cur_ch    = cur_ch_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;
  assign overflow  = overflow_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_fq_scheduler.sv
module tb_fq_scheduler;

  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;
  // Channels 0, 2 and 3 toggle every 2 ref cycles (one rise per 4); channel 1 is silent.
  localparam logic [CHANNELS-1:0] SIG_EN = 4'b1101;

  logic                clk = 1'b0;
  logic                Reset;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] sig_in;
  logic [31:0]         gate_cycles;
  logic                ready;
  logic [1:0]          ph = '0;

  logic                busy, overflow, valid;
  logic [CH_W-1:0]     cur_ch, result_ch;
  logic [31:0]         result;

  logic                ds_busy, ds_overflow, ds_valid;
  logic [CH_W-1:0]     ds_cur_ch, ds_result_ch;
  logic [3:0]          ds_result;

  int n_checks = 0;
  int n_errors = 0;
  int c;
  int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 3, 1};

  always #5 clk = ~clk;
  always @(negedge clk) ph <= ph + 2'd1;
  assign sig_in = {CHANNELS{ph[1]}} & SIG_EN;

  fq_scheduler #(.CHANNELS(CHANNELS), .WIDTH(32)) dut (
    .ref_freq(clk), .Reset(Reset), .req(req), .sig_in(sig_in),
    .gate_cycles(gate_cycles), .busy(busy), .cur_ch(cur_ch), .result(result),
    .result_ch(result_ch), .overflow(overflow), .valid(valid), .ready(ready));

  fq_scheduler #(.CHANNELS(CHANNELS), .WIDTH(4)) dut_s (
    .ref_freq(clk), .Reset(Reset), .req(req), .sig_in(sig_in),
    .gate_cycles(gate_cycles), .busy(ds_busy), .cur_ch(ds_cur_ch), .result(ds_result),
    .result_ch(ds_result_ch), .overflow(ds_overflow), .valid(ds_valid), .ready(ready));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!valid && cycles < budget);
    if (!valid) chk("valid_timeout", 64'(valid), 64'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    Reset = 1'b1; req = '0; gate_cycles = 32'd0; ready = 1'b0;
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cur_ch", 64'(cur_ch), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_ch", 64'(result_ch), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    repeat (2) step();
    Reset = 1'b0;
    repeat (12) step();

    // Single channel, gate changed after grant must not matter.
    req = 4'b0100; gate_cycles = 32'd100;
    step();
    chk("single_grant_busy", 64'(busy), 64'd1);
    chk("single_grant_ch", 64'(cur_ch), 64'd2);
    gate_cycles = 32'd5;
    wait_valid(200, c);
    chk("single_gate_len", 64'(c), 64'd100);
    chk("single_result", 64'(result), 64'd25);
    chk("single_result_ch", 64'(result_ch), 64'd2);
    chk("single_overflow", 64'(overflow), 64'd0);
    req = '0; ready = 1'b1;
    step();
    chk("single_hs", {62'd0, valid, busy}, 64'd0);
    ready = 1'b0;

    // Round robin from reset, then a sparser request pattern.
    do_reset();
    req = 4'b1111; gate_cycles = 32'd8; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid(40, c);
      chk("rr_ch", 64'(result_ch), 64'(exp_ch[k]));
      chk("rr_spacing", 64'(c), (k == 0) ? 64'd9 : 64'd10);
      if (k == 4) req = 4'b1010;
    end
    req = '0;
    step();
    chk("rr_idle", 64'(busy), 64'd0);
    ready = 1'b0;

    // Saturation on the 4-bit instance, then a silent channel.
    do_reset();
    req = 4'b0001; gate_cycles = 32'd200;
    wait_valid(300, c);
    chk("ovf_gate_len", 64'(c), 64'd201);
    chk("ovf_small_result", 64'(ds_result), 64'd15);
    chk("ovf_small_flag", 64'(ds_overflow), 64'd1);
    chk("ovf_wide_result", 64'(result), 64'd50);
    chk("ovf_wide_flag", 64'(overflow), 64'd0);
    req = 4'b0010; gate_cycles = 32'd20; ready = 1'b1;
    wait_valid(60, c);
    chk("zero_latency", 64'(c), 64'd22);
    chk("zero_small_result", 64'(ds_result), 64'd0);
    chk("zero_small_flag", 64'(ds_overflow), 64'd0);
    chk("zero_small_ch", 64'(ds_result_ch), 64'd1);
    req = '0;
    step();
    ready = 1'b0;

    // Backpressure: HOLD ignores another requester until the handshake.
    do_reset();
    req = 4'b0001; gate_cycles = 32'd12;
    wait_valid(40, c);
    chk("bp_gate_len", 64'(c), 64'd13);
    req = 4'b0101;
    repeat (20) begin
      step();
      chk("bp_hold", 64'({valid, busy, cur_ch, result_ch, overflow, result}),
          64'({1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 32'd3}));
    end
    ready = 1'b1;
    step();
    chk("bp_hs", {62'd0, valid, busy}, 64'd0);
    ready = 1'b0;
    step();
    chk("bp_next_grant", {61'd0, busy, cur_ch}, {61'd0, 1'b1, 2'd2});
    req = '0;
    step();
    chk("bp_abort", 64'(busy), 64'd0);

    // Abort mid-gate, then a pending channel with a zero gate.
    do_reset();
    req = 4'b0110; gate_cycles = 32'd50;
    step();
    chk("ab_grant_ch", 64'(cur_ch), 64'd1);
    repeat (24) step();
    req = 4'b0100; gate_cycles = 32'd0;
    step();
    chk("ab_drop", {62'd0, valid, busy}, 64'd0);
    step();
    chk("g0_grant", {60'd0, valid, busy, cur_ch}, {60'd0, 1'b0, 1'b1, 2'd2});
    step();
    chk("g0_valid", {61'd0, valid, result_ch}, {61'd0, 1'b1, 2'd2});
    req = '0; ready = 1'b1;
    step();
    chk("g0_hs", 64'(valid), 64'd0);
    ready = 1'b0;

    // Asynchronous reset mid-GATE and mid-HOLD.
    req = 4'b0100; gate_cycles = 32'd20;
    repeat (5) step();
    chk("rg_busy_before", {61'd0, busy, cur_ch}, {61'd0, 1'b1, 2'd2});
    #3 Reset = 1'b1;
    #1 chk("rst_mid_gate", 64'({busy, cur_ch, result_ch, overflow, valid, result}), 64'd0);
    #2 Reset = 1'b0;
    req = '0;
    repeat (4) step();
    req = 4'b0100; gate_cycles = 32'd12;
    wait_valid(40, c);
    chk("rh_result", {30'd0, result_ch, result}, {30'd0, 2'd2, 32'd3});
    #3 Reset = 1'b1;
    #1 chk("rst_mid_hold", 64'({busy, cur_ch, result_ch, overflow, valid, result}), 64'd0);
    #2 Reset = 1'b0;
    req = '0;
    repeat (4) step();
    req = 4'b1000; ready = 1'b1;
    wait_valid(40, c);
    chk("post_rst_len", 64'(c), 64'd13);
    chk("post_rst_result", {30'd0, result_ch, result}, {30'd0, 2'd3, 32'd3});
    req = '0;
    step();
    ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fq_scheduler.md
# fq_scheduler

Multi-channel frequency measurement scheduler. Up to CHANNELS asynchronous input signals share one edge counter clocked by the reference clock. Requesters raise a per-channel request; the block grants channels round-robin, counts the granted signal's rising edges over a programmable gate window, and returns the count with a valid/ready handshake. It sits between the measured signal pins and the host/readout logic.

## Interface

**Parameters**
- CHANNELS, 4: number of measured inputs, 2..16.
- WIDTH, 32: width of the edge counter and of `result`.
- CH_W, $clog2(CHANNELS): width of channel indices.

**Ports**
- ref_freq  in  1  the single clock (reference clock); all logic is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  CHANNELS  per-channel request level; held high until the result handshake for that channel.
- sig_in  in  CHANNELS  measured signals, asynchronous to ref_freq.
- gate_cycles  in  32  gate window length in ref_freq cycles; sampled at grant.
- busy  out  1  high from grant until handshake or abort.
- cur_ch  out  CH_W  channel currently granted; holds the last grant while idle.
- result  out  WIDTH  edge count of the completed measurement.
- result_ch  out  CH_W  channel that `result` belongs to.
- overflow  out  1  count saturated during this measurement.
- valid  out  1  result available.
- ready  in  1  consumer accepts the result when valid && ready.

## Operation

**Synchronisation**
- Every channel has a free-running 2-FF synchroniser s1→s2 plus a history register s3.
- rise[i] = s2[i] & ~s3[i].
- All channels are always synchronised, so switching channels needs no settle time.

**State machine**
- IDLE
  - If any req bit is high, grant the first requesting channel at or above `rr_ptr`, wrapping.
  - On grant: cur_ch ← channel, edge_cnt ← 0, gate_cnt ← max(gate_cycles, 1), overflow ← 0, busy ← 1, go to GATE.
- GATE
  - Each cycle: if rise[cur_ch], edge_cnt increments. At all-ones it saturates and sets overflow.
  - gate_cnt decrements each cycle.
  - On the cycle where gate_cnt == 1, that cycle's rise is still included: result ← final count, result_ch ← cur_ch, valid ← 1, go to HOLD.
  - If req[cur_ch] is low in any GATE cycle, abort: no result, busy ← 0, rr_ptr ← cur_ch+1 (wrapping), go to IDLE.
- HOLD
  - valid, result, result_ch and overflow are held stable.
  - req is ignored.
  - On valid && ready: valid ← 0, busy ← 0, rr_ptr ← cur_ch+1 (wrapping), go to IDLE.

**Arithmetic and limits**
- Counts are WIDTH-bit unsigned and saturating; no wrap-around.
- Correct counting requires sig_in frequency < ref_freq/2.
- gate_cycles = 0 is treated as 1.
- Frequency = result × f_ref / gate_cycles; the block does not perform this division.

**Boundary rules**
- A requester that keeps req high after its handshake is served again only after the other requesters, per round-robin order.
- Changes to gate_cycles during GATE have no effect.
- Reset in any state forces IDLE immediately, clears rr_ptr and all synchroniser registers, and discards any measurement in progress.

## Timing

- Reset values: busy 0, cur_ch 0, result 0, result_ch 0, overflow 0, valid 0; rr_ptr 0; state IDLE.
- sig_in rising edge to rise pulse: 2–3 cycles (synchroniser latency).
- req high in IDLE (sampled edge N) to state GATE and busy high: edge N.
- The first counted cycle is N+1.
- The gate covers exactly max(gate_cycles,1) cycles, N+1..N+G.
- valid rises at edge N+G.
- Handshake at edge M gives valid low at M. The next grant is possible at M+1, so the minimum gap between measurements is 1 IDLE cycle.
- Abort: a req low sampled at edge K gives busy low at K; there is no valid pulse.

## Test plan

- **Single channel:** CHANNELS=4; req=0100, gate_cycles=100, sig_in[2] toggling every 2 ref cycles (rise every 4 cycles), pre-running ≥10 cycles → valid after 100 gate cycles, result=25, result_ch=2, overflow=0. Then ready=1 → valid and busy low.
- **Round robin:** req=1111 held, ready=1, gate_cycles=8 → result_ch sequence 0,1,2,3,0. Then req=1010 → next grants 1,3,1.
- **Overflow:** WIDTH=4, sig_in at ref/4 rate, gate_cycles=200 → result=15, overflow=1. A following measurement of a 0-edge channel gives result=0, overflow=0.
- **Backpressure:** ready=0 for 20 cycles after valid, with req on another channel → result/result_ch/overflow stable, busy=1, cur_ch unchanged, no grant. ready=1 → handshake; the other channel is granted 1 cycle later.
- **Abort and gate 0:** drop req[1] midway through a 50-cycle gate → busy low that cycle, no valid; req[2] pending is granted next. Then gate_cycles=0 → 1-cycle gate, valid 1 cycle after grant.
- **Reset:** assert Reset asynchronously mid-GATE and mid-HOLD → all outputs 0 at once, state IDLE. After release, req=1000 with rr_ptr=0 grants channel 3 and measures correctly.
